// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word RAM.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  // Number of index bits needed to address `value` words.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_wordram.sv
// Single-port synchronous 32-bit RAM, registered read, write-first on a write.
// clr zeroes the read register and suppresses any access in that cycle.
module dmem_wordram #(
  parameter int    WORDS     = 1024,
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the D-cache port: captures a level-held request,
// waits LATENCY cycles, then pulses memory_response with the read word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read_request,
  input  logic        memory_write_request,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_write_data,
  output logic        memory_response,
  output logic [31:0] memory_read_data,
  output logic        memory_error,
  output logic [1:0]  debug_state
);

  localparam int             IDX_W    = clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [31:0]    WORDS_L  = 32'(MEM_WORDS);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [29:0]      lat_idx;
  logic [31:0]      lat_wdata;
  logic             lat_write;
  logic             err_q;

  logic             req, capture, access, acc_write, acc_oor;
  logic [29:0]      acc_idx;
  logic [31:0]      acc_wdata;
  logic             unused_addr_lsbs;

  assign req              = memory_read_request | memory_write_request;
  assign unused_addr_lsbs = ^memory_addr[1:0];

  // The RAM access happens on the edge that enters RESP. With LATENCY=1 that
  // is the capture edge itself, so the live inputs feed the access directly.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    acc_idx   = lat_idx;
    acc_wdata = lat_wdata;
    acc_write = lat_write;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            access    = 1'b1;
            acc_idx   = memory_addr[31:2];
            acc_wdata = memory_write_data;
            acc_write = memory_write_request;
            cnt_n     = '0;
            state_n   = RESP;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        // The counter reaches zero on the edge that performs the access.
        if (cnt <= CNT_W'(1)) begin
          access  = 1'b1;
          cnt_n   = '0;
          state_n = RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP:    state_n = RECOVER;
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign acc_oor = {2'b00, acc_idx} >= WORDS_L;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        lat_idx   <= memory_addr[31:2];
        lat_wdata <= memory_write_data;
        lat_write <= memory_write_request;
      end
      if (access) err_q <= acc_oor;
    end
  end

  // Out-of-range accesses never touch the array; they just zero the read word.
  dmem_wordram #(
    .WORDS    (MEM_WORDS),
    .AW       (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .clr  (reset | (access & acc_oor)),
    .en   (access & ~acc_oor & ~reset),
    .we   (acc_write),
    .addr (acc_idx[IDX_W-1:0]),
    .wdata(acc_wdata),
    .rdata(memory_read_data)
  );

  assign memory_response = (state == RESP);
  assign memory_error    = (state == RESP) & err_q;
  assign debug_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance, directed
// table vectors, hand-written timing/reset sequences and a random model run.
module tb_dmem_responder;

  localparam int MW = 1024;

  // Valid/ready-style contract seen by the cache: a request is a level held
  // until the one-cycle memory_response pulse; the responder ignores requests
  // outside IDLE, so a request still high in RECOVER is not a new transaction.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd0, wr0, resp0, err0, rd1, wr1, resp1, err1;
  logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic [1:0]  dbg0, dbg1;

  dmem_responder #(.MEM_WORDS(MW), .LATENCY(2), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .memory_read_request(rd0), .memory_write_request(wr0),
    .memory_addr(addr0), .memory_write_data(wdata0),
    .memory_response(resp0), .memory_read_data(rdata0),
    .memory_error(err0), .debug_state(dbg0)
  );

  dmem_responder #(.MEM_WORDS(MW), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset),
    .memory_read_request(rd1), .memory_write_request(wr1),
    .memory_addr(addr1), .memory_write_data(wdata1),
    .memory_response(resp1), .memory_read_data(rdata1),
    .memory_error(err1), .debug_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [2][8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic o_resp(input int d);
    return (d == 0) ? resp0 : resp1;
  endfunction
  function automatic logic o_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic [31:0] o_rdata(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd;
    end
  endtask

  // One cache transaction: request held through the response and RECOVER,
  // address/data scrambled after capture, dropped once RECOVER is seen.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err,
                        input string name);
    int lat;
    logic [31:0] held;
    bit seen;
    int exp_lat;
    exp_lat = (d == 0) ? 2 : 1;
    @(negedge clk);
    drive(d, rd, wr, a, wd);
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (o_resp(d)) begin
        seen = 1;
        lat  = k;
      end
      drive(d, rd, wr, $urandom, $urandom);
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      drive(d, 1'b0, 1'b0, '0, '0);
      repeat (4) @(negedge clk);
      return;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_data"}, o_rdata(d), exp_data);
    check({name, "_error"}, 32'(o_err(d)), 32'(exp_err));
    held = o_rdata(d);
    @(negedge clk);
    check({name, "_single_pulse"}, 32'(o_resp(d)), 32'd0);
    check({name, "_data_held"}, o_rdata(d), held);
    drive(d, 1'b0, 1'b0, '0, '0);
  endtask

  // Request held continuously: responses every LATENCY+2 cycles.
  task automatic held_requests(input int d, input int lat, input string name);
    logic [31:0] got_q[$];
    @(negedge clk);
    drive(d, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = lat; c <= 11; c += lat + 2) exp_q.push_back(32'(c));
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (o_resp(d)) got_q.push_back(32'(k));
    end
    drive(d, 1'b0, 1'b0, '0, '0);
    check({name, "_pulse_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_pulse_cycle"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          d;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd, ed;
    int idx, op;
    logic oor, e_err;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_resp0", 32'(resp0), 32'd0);
    check("reset_err0", 32'(err0), 32'd0);
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_state0", 32'(dbg0), 32'd0);
    check("reset_rdata1", rdata1, 32'h0);

    tbl.push_back('{0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "wr_10"});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rd_10"});
    tbl.push_back('{0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'h12345678, 1'b0, "rdwr_20"});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, "rd_20"});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "wr_0"});
    tbl.push_back('{0, 1'b0, 1'b1, MW * 4, 32'hFFFFFFFF, 32'h0, 1'b1, "wr_oor"});
    tbl.push_back('{0, 1'b1, 1'b0, MW * 4, 32'h0, 32'h0, 1'b1, "rd_oor"});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "rd_0_after_oor"});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h3, 32'h0, 32'hCAFEF00D, 1'b0, "rd_lsbs_ignored"});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, "wr_40"});
    tbl.push_back('{1, 1'b0, 1'b1, 32'h10, 32'h13579BDF, 32'h13579BDF, 1'b0, "l1_wr_10"});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h13579BDF, 1'b0, "l1_rd_10"});
    tbl.push_back('{1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, "l1_rd_oor"});

    for (int i = 0; i < tbl.size(); i++)
      access(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
             tbl[i].exp_d, tbl[i].exp_e, tbl[i].name);

    // Reset in WAIT of a write to 0x40: write discarded, outputs cleared.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h40, 32'h11111111);
    @(negedge clk);
    check("abort_in_wait_state", 32'(dbg0), 32'd1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_resp", 32'(resp0), 32'd0);
    check("abort_err", 32'(err0), 32'd0);
    check("abort_rdata", rdata0, 32'h0);
    check("abort_state", 32'(dbg0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp0), 32'd0);
    end
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0, "rd_40_after_abort");

    held_requests(0, 2, "held_l2");
    held_requests(1, 1, "held_l1");

    // Random run against a word-array model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        wd = $urandom;
        mdl[d][i] = wd;
        access(d, 1'b0, 1'b1, 32'(i * 4), wd, wd, 1'b0, "rnd_fill");
      end
      for (int n = 0; n < 40; n++) begin
        op  = $urandom_range(0, 2);
        oor = ($urandom_range(0, 7) == 0);
        idx = $urandom_range(0, 7);
        if (oor) a = ($urandom_range(MW, 32'h3FFFFFFF) << 2) | $urandom_range(0, 3);
        else     a = 32'(idx * 4) | $urandom_range(0, 3);
        wd = $urandom;
        if (oor) begin
          ed    = 32'h0;
          e_err = 1'b1;
        end else begin
          ed    = (op != 0) ? wd : mdl[d][idx];
          e_err = 1'b0;
          if (op != 0) mdl[d][idx] = wd;
        end
        access(d, (op != 1), (op != 0), a, wd, ed, e_err, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
